// File: rtl/ysram_read_arbiter_if.sv
// Request/response and SRAM read-port bundle for ysram_read_arbiter.
// master = requesters + SRAM macro side, slave = the arbiter.
interface ysram_read_arbiter_if;
    logic         req0_valid;
    logic [15:0]  req0_row;
    logic         req0_ready;
    logic         resp0_valid;
    logic [255:0] resp0_data;
    logic         resp0_err;

    logic         req1_valid;
    logic [15:0]  req1_row;
    logic         req1_ready;
    logic         resp1_valid;
    logic [255:0] resp1_data;
    logic         resp1_err;

    logic [10:0]  ysram_addr;
    logic         ysram_rd_en;
    logic [255:0] ysram_rdata;

    modport slave (
        input  req0_valid, req0_row, req1_valid, req1_row, ysram_rdata,
        output req0_ready, resp0_valid, resp0_data, resp0_err,
        output req1_ready, resp1_valid, resp1_data, resp1_err,
        output ysram_addr, ysram_rd_en
    );

    modport master (
        output req0_valid, req0_row, req1_valid, req1_row, ysram_rdata,
        input  req0_ready, resp0_valid, resp0_data, resp0_err,
        input  req1_ready, resp1_valid, resp1_data, resp1_err,
        input  ysram_addr, ysram_rd_en
    );
endinterface

// File: rtl/ysram_read_arbiter.sv
// Two-requester arbiter for the Y-matrix SRAM read port, one read outstanding.
// Define YSRAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 wins ties.
//
// state   | meaning
// IDLE    | ready offered to the arbitration winner
// ISSUE   | one-cycle SRAM read strobe, or skip straight to RESP on range error
// WAIT    | terminal-count down-counter covering READ_LAT
// RESP    | one-cycle response pulse to the granted requester
module ysram_read_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ysram_read_arbiter_if.slave  io_bus,
    output logic                 o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]   r_state;
    logic         r_gnt;
    logic         r_err_pend;
    logic [10:0]  r_addr;
    logic [2:0]   r_cnt;
    logic [255:0] r_data0;
    logic [255:0] r_data1;
    logic         r_err0;
    logic         r_err1;

    logic         w_idle;
    logic         w_pick1;
    logic         w_accept;
    logic [15:0]  w_row;
    logic         w_row_err;

`ifdef YSRAM_ARB_RR_EN
    // r_ptr = 1 means requester 1 is favoured on the next tie
    logic r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_pick1;
        end
    end

    assign w_pick1 = io_bus.req1_valid & (~io_bus.req0_valid | r_ptr);
`else
    assign w_pick1 = io_bus.req1_valid & ~io_bus.req0_valid;
`endif

    assign w_idle    = (r_state == S_IDLE) & ~i_rst;
    assign w_accept  = w_idle & (io_bus.req0_valid | io_bus.req1_valid);
    assign w_row     = w_pick1 ? io_bus.req1_row : io_bus.req0_row;
    assign w_row_err = |w_row[15:11];

    assign io_bus.req0_ready  = w_idle & io_bus.req0_valid & ~w_pick1;
    assign io_bus.req1_ready  = w_idle & w_pick1;
    assign io_bus.ysram_rd_en = (r_state == S_ISSUE) & ~r_err_pend;
    assign io_bus.ysram_addr  = r_addr;
    assign io_bus.resp0_valid = (r_state == S_RESP) & ~r_gnt;
    assign io_bus.resp1_valid = (r_state == S_RESP) & r_gnt;
    assign io_bus.resp0_data  = r_data0;
    assign io_bus.resp1_data  = r_data1;
    assign io_bus.resp0_err   = r_err0;
    assign io_bus.resp1_err   = r_err1;
    assign o_busy             = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b0;
            r_err_pend <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt      <= w_pick1;
                        r_err_pend <= w_row_err;
                        // the address only moves for requests that really reach the SRAM
                        if (!w_row_err) begin
                            r_addr <= w_row[10:0];
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_err_pend) begin
                        if (r_gnt) begin
                            r_data1 <= '0;
                            r_err1  <= 1'b1;
                        end else begin
                            r_data0 <= '0;
                            r_err0  <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= 3'(READ_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_gnt) begin
                            r_data1 <= io_bus.ysram_rdata;
                            r_err1  <= 1'b0;
                        end else begin
                            r_data0 <= io_bus.ysram_rdata;
                            r_err0  <= 1'b0;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysram_read_arbiter.sv
// Self-checking bench for ysram_read_arbiter: directed scenarios plus a randomized
// run against a transaction-level timing/arbitration model. Two DUTs: READ_LAT=1 and 3.
module tb_ysram_read_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
`ifdef YSRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_a;
    logic busy_b;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    bit   ptr_m = 1'b0;

    ysram_read_arbiter_if ifa ();
    ysram_read_arbiter_if ifb ();

    ysram_read_arbiter #(.READ_LAT(LAT_A)) u_dut_a (
        .i_clk (clk), .i_rst (rst), .io_bus (ifa), .o_busy (busy_a)
    );
    ysram_read_arbiter #(.READ_LAT(LAT_B)) u_dut_b (
        .i_clk (clk), .i_rst (rst), .io_bus (ifb), .o_busy (busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [10:0] a);
        if (a == 11'h005) return {32{8'hA5}};
        return {8{32'h1234_0000 + {21'h0, a}}};
    endfunction

    function automatic logic [255:0] gen(input int n);
        return {8{32'hD000_0000 ^ 32'(n)}};
    endfunction

    function automatic logic [15:0] rand_row();
        if ($urandom_range(0, 4) == 0)
            return {5'($urandom_range(1, 31)), 11'($urandom)};
        return {5'b0, 11'($urandom_range(0, 63))};
    endfunction

    // SRAM models: A answers pat(addr) one cycle after the strobe; B changes every cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) ifa.ysram_rdata <= '0;
        else if (ifa.ysram_rd_en) ifa.ysram_rdata <= pat(ifa.ysram_addr);
        ifb.ysram_rdata <= gen(cyc + 1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        ifa.req0_valid = 1'b1; ifa.req0_row = 16'h0005;
        ifa.req1_valid = 1'b1; ifa.req1_row = 16'h0006;
        ifb.req0_valid = 1'b1; ifb.req0_row = 16'h0007;
        ifb.req1_valid = 1'b0; ifb.req1_row = 16'h0000;
        tick(); tick(); #1;
        total++; if (ifa.req0_ready !== 1'b0) $display("FAIL rst_ready0 got=%b exp=0", ifa.req0_ready); else passed++;
        total++; if (ifa.req1_ready !== 1'b0) $display("FAIL rst_ready1 got=%b exp=0", ifa.req1_ready); else passed++;
        total++; if (ifb.req0_ready !== 1'b0) $display("FAIL rst_b_ready0 got=%b exp=0", ifb.req0_ready); else passed++;
        total++; if (ifa.ysram_rd_en !== 1'b0) $display("FAIL rst_rd_en got=%b exp=0", ifa.ysram_rd_en); else passed++;
        total++; if (ifa.ysram_addr !== 11'h000) $display("FAIL rst_addr got=%h exp=000", ifa.ysram_addr); else passed++;
        total++; if ({ifa.resp0_valid, ifa.resp1_valid} !== 2'b00) $display("FAIL rst_resp_valid got=%b exp=00", {ifa.resp0_valid, ifa.resp1_valid}); else passed++;
        total++; if ({ifa.resp0_err, ifa.resp1_err} !== 2'b00) $display("FAIL rst_resp_err got=%b exp=00", {ifa.resp0_err, ifa.resp1_err}); else passed++;
        total++; if (ifa.resp0_data !== '0) $display("FAIL rst_resp0_data got=%h exp=0", ifa.resp0_data); else passed++;
        total++; if (ifa.resp1_data !== '0) $display("FAIL rst_resp1_data got=%h exp=0", ifa.resp1_data); else passed++;
        total++; if ({busy_a, busy_b} !== 2'b00) $display("FAIL rst_busy got=%b exp=00", {busy_a, busy_b}); else passed++;
        tick();
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0; ifb.req0_valid = 1'b0;
        rst = 1'b0;
        ptr_m = 1'b0;
    endtask

    task automatic test_single();
        tick(); ifa.req0_valid = 1'b1; ifa.req0_row = 16'h0005; #1;
        total++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) $display("FAIL single_ready got=%b exp=10", {ifa.req0_ready, ifa.req1_ready}); else passed++;
        ptr_m = 1'b1;
        tick(); ifa.req0_valid = 1'b0; #1;
        total++; if (ifa.ysram_rd_en !== 1'b1) $display("FAIL single_rd_en got=%b exp=1", ifa.ysram_rd_en); else passed++;
        total++; if (ifa.ysram_addr !== 11'h005) $display("FAIL single_addr got=%h exp=005", ifa.ysram_addr); else passed++;
        total++; if (busy_a !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy_a); else passed++;
        tick(); #1;
        total++; if (ifa.ysram_rd_en !== 1'b0) $display("FAIL single_rd_en_once got=%b exp=0", ifa.ysram_rd_en); else passed++;
        total++; if (ifa.resp0_valid !== 1'b0) $display("FAIL single_early_resp got=%b exp=0", ifa.resp0_valid); else passed++;
        tick(); #1;
        total++; if (ifa.resp0_valid !== 1'b1) $display("FAIL single_resp_valid got=%b exp=1", ifa.resp0_valid); else passed++;
        total++; if (ifa.resp0_data !== {32{8'hA5}}) $display("FAIL single_data got=%h exp=%h", ifa.resp0_data, {32{8'hA5}}); else passed++;
        total++; if (ifa.resp0_err !== 1'b0) $display("FAIL single_err got=%b exp=0", ifa.resp0_err); else passed++;
        total++; if (ifa.resp1_valid !== 1'b0) $display("FAIL single_resp1 got=%b exp=0", ifa.resp1_valid); else passed++;
        tick(); #1;
        total++; if ({ifa.resp0_valid, busy_a} !== 2'b00) $display("FAIL single_done got=%b exp=00", {ifa.resp0_valid, busy_a}); else passed++;
    endtask

    task automatic test_out_of_range();
        tick(); ifa.req1_valid = 1'b1; ifa.req1_row = 16'h0033; #1;
        total++; if (ifa.req1_ready !== 1'b1) $display("FAIL oor_pre_ready got=%b exp=1", ifa.req1_ready); else passed++;
        ptr_m = 1'b0;
        tick(); ifa.req1_valid = 1'b0;
        repeat (3) tick();
        ifa.req1_valid = 1'b1; ifa.req1_row = 16'h0800; #1;
        total++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) $display("FAIL oor_ready got=%b exp=01", {ifa.req0_ready, ifa.req1_ready}); else passed++;
        ptr_m = 1'b0;
        tick(); ifa.req1_valid = 1'b0; #1;
        total++; if (ifa.ysram_rd_en !== 1'b0) $display("FAIL oor_rd_en got=%b exp=0", ifa.ysram_rd_en); else passed++;
        total++; if (ifa.ysram_addr !== 11'h033) $display("FAIL oor_addr_hold got=%h exp=033", ifa.ysram_addr); else passed++;
        tick(); #1;
        total++; if (ifa.resp1_valid !== 1'b1) $display("FAIL oor_resp_valid got=%b exp=1", ifa.resp1_valid); else passed++;
        total++; if (ifa.resp1_err !== 1'b1) $display("FAIL oor_err got=%b exp=1", ifa.resp1_err); else passed++;
        total++; if (ifa.resp1_data !== '0) $display("FAIL oor_data got=%h exp=0", ifa.resp1_data); else passed++;
        total++; if (ifa.resp0_valid !== 1'b0) $display("FAIL oor_resp0 got=%b exp=0", ifa.resp0_valid); else passed++;
        tick(); #1;
        total++; if ({ifa.resp1_valid, busy_a} !== 2'b00) $display("FAIL oor_done got=%b exp=00", {ifa.resp1_valid, busy_a}); else passed++;
    endtask

    task automatic test_contention();
        bit e1;
        logic [10:0] ea;
        tick();
        ifa.req0_valid = 1'b1; ifa.req0_row = 16'h0010;
        ifa.req1_valid = 1'b1; ifa.req1_row = 16'h0020;
        #1;
        for (int g = 0; g < 4; g++) begin
            e1 = RR_EN ? ptr_m : 1'b0;
            ea = e1 ? 11'h020 : 11'h010;
            total++; if ({ifa.req0_ready, ifa.req1_ready} !== {~e1, e1}) $display("FAIL cont_grant%0d got=%b exp=%b", g, {ifa.req0_ready, ifa.req1_ready}, {~e1, e1}); else passed++;
            ptr_m = ~e1;
            tick();
            if (g == 3) begin ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0; end
            #1;
            total++; if ({ifa.ysram_rd_en, ifa.ysram_addr} !== {1'b1, ea}) $display("FAIL cont_issue%0d got=%b/%h exp=1/%h", g, ifa.ysram_rd_en, ifa.ysram_addr, ea); else passed++;
            total++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b00) $display("FAIL cont_busy_ready%0d got=%b exp=00", g, {ifa.req0_ready, ifa.req1_ready}); else passed++;
            tick(); tick(); #1;
            total++; if ({ifa.resp0_valid, ifa.resp1_valid} !== {~e1, e1}) $display("FAIL cont_resp_port%0d got=%b exp=%b", g, {ifa.resp0_valid, ifa.resp1_valid}, {~e1, e1}); else passed++;
            total++; if ((e1 ? ifa.resp1_data : ifa.resp0_data) !== pat(ea)) $display("FAIL cont_data%0d got=%h exp=%h", g, (e1 ? ifa.resp1_data : ifa.resp0_data), pat(ea)); else passed++;
            tick(); #1;
        end
    endtask

    task automatic test_lat3();
        int k;
        tick(); ifb.req0_valid = 1'b1; ifb.req0_row = 16'h0007; #1;
        total++; if (ifb.req0_ready !== 1'b1) $display("FAIL lat3_ready got=%b exp=1", ifb.req0_ready); else passed++;
        tick(); ifb.req0_valid = 1'b0; #1;
        k = cyc;
        total++; if ({ifb.ysram_rd_en, ifb.ysram_addr} !== {1'b1, 11'h007}) $display("FAIL lat3_issue got=%b/%h exp=1/007", ifb.ysram_rd_en, ifb.ysram_addr); else passed++;
        for (int i = 2; i <= 5; i++) begin
            tick(); #1;
            total++; if (ifb.ysram_rd_en !== 1'b0) $display("FAIL lat3_rd_en_t%0d got=%b exp=0", i, ifb.ysram_rd_en); else passed++;
            total++; if (ifb.resp0_valid !== (i == 5)) $display("FAIL lat3_resp_t%0d got=%b exp=%b", i, ifb.resp0_valid, (i == 5)); else passed++;
        end
        total++; if (ifb.resp0_data !== gen(k + LAT_B)) $display("FAIL lat3_data got=%h exp=%h", ifb.resp0_data, gen(k + LAT_B)); else passed++;
        total++; if (ifb.resp0_err !== 1'b0) $display("FAIL lat3_err got=%b exp=0", ifb.resp0_err); else passed++;
        tick();
    endtask

    task automatic test_reset_in_wait();
        tick(); ifa.req0_valid = 1'b1; ifa.req0_row = 16'h0044; #1;
        total++; if (ifa.req0_ready !== 1'b1) $display("FAIL rstw_ready got=%b exp=1", ifa.req0_ready); else passed++;
        tick(); ifa.req0_valid = 1'b0; #1;
        total++; if (ifa.ysram_rd_en !== 1'b1) $display("FAIL rstw_rd_en got=%b exp=1", ifa.ysram_rd_en); else passed++;
        tick(); rst = 1'b1; #1;
        total++; if (busy_a !== 1'b1) $display("FAIL rstw_busy_before got=%b exp=1", busy_a); else passed++;
        tick(); #1;
        total++; if ({ifa.resp0_valid, ifa.resp1_valid, busy_a, ifa.ysram_rd_en} !== 4'b0000) $display("FAIL rstw_ctrl got=%b exp=0000", {ifa.resp0_valid, ifa.resp1_valid, busy_a, ifa.ysram_rd_en}); else passed++;
        total++; if (ifa.resp0_data !== '0) $display("FAIL rstw_data got=%h exp=0", ifa.resp0_data); else passed++;
        total++; if ({ifa.resp0_err, ifa.ysram_addr} !== 12'h000) $display("FAIL rstw_err_addr got=%b/%h exp=0/000", ifa.resp0_err, ifa.ysram_addr); else passed++;
        rst = 1'b0;
        ptr_m = 1'b0;
        tick(); ifa.req1_valid = 1'b1; ifa.req1_row = 16'h0021; #1;
        total++; if (ifa.resp0_valid !== 1'b0) $display("FAIL rstw_no_resp got=%b exp=0", ifa.resp0_valid); else passed++;
        total++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) $display("FAIL rstw_new_grant got=%b exp=01", {ifa.req0_ready, ifa.req1_ready}); else passed++;
        ptr_m = 1'b0;
        tick(); ifa.req1_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        int free_at, acc_cyc, rd_cyc, resp_cyc, c;
        bit resp_port, resp_err, drop0, drop1, any, e1, err;
        logic [10:0] rd_addr;
        logic [15:0] grow;
        logic [255:0] resp_data, got_data;
        free_at = 0; acc_cyc = -1; rd_cyc = -1; resp_cyc = -1;
        resp_port = 1'b0; resp_err = 1'b0; resp_data = '0; rd_addr = '0;
        drop0 = 1'b0; drop1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            tick();
            c = cyc;
            if (drop0) begin ifa.req0_valid = 1'b0; drop0 = 1'b0; end
            if (drop1) begin ifa.req1_valid = 1'b0; drop1 = 1'b0; end
            if (!ifa.req0_valid && $urandom_range(0, 2) == 0) begin ifa.req0_valid = 1'b1; ifa.req0_row = rand_row(); end
            if (!ifa.req1_valid && $urandom_range(0, 2) == 0) begin ifa.req1_valid = 1'b1; ifa.req1_row = rand_row(); end
            #1;
            any = (c >= free_at) && (ifa.req0_valid || ifa.req1_valid);
            e1  = ifa.req1_valid && (!ifa.req0_valid || (RR_EN && ptr_m));
            total++; if ({ifa.req0_ready, ifa.req1_ready} !== {any && !e1, any && e1}) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {ifa.req0_ready, ifa.req1_ready}, {any && !e1, any && e1}); else passed++;
            total++; if (ifa.ysram_rd_en !== (c == rd_cyc)) $display("FAIL rnd_rd_en c=%0d got=%b exp=%b", c, ifa.ysram_rd_en, (c == rd_cyc)); else passed++;
            if (c == rd_cyc) begin
                total++; if (ifa.ysram_addr !== rd_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, ifa.ysram_addr, rd_addr); else passed++;
            end
            total++; if ({ifa.resp0_valid, ifa.resp1_valid} !== {c == resp_cyc && !resp_port, c == resp_cyc && resp_port}) $display("FAIL rnd_resp_valid c=%0d got=%b exp=%b", c, {ifa.resp0_valid, ifa.resp1_valid}, {c == resp_cyc && !resp_port, c == resp_cyc && resp_port}); else passed++;
            if (c == resp_cyc) begin
                got_data = resp_port ? ifa.resp1_data : ifa.resp0_data;
                total++; if (got_data !== resp_data) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, got_data, resp_data); else passed++;
                total++; if ((resp_port ? ifa.resp1_err : ifa.resp0_err) !== resp_err) $display("FAIL rnd_err c=%0d got=%b exp=%b", c, (resp_port ? ifa.resp1_err : ifa.resp0_err), resp_err); else passed++;
            end
            total++; if (busy_a !== (c > acc_cyc && c <= resp_cyc)) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_a, (c > acc_cyc && c <= resp_cyc)); else passed++;
            if (any) begin
                grow      = e1 ? ifa.req1_row : ifa.req0_row;
                err       = |grow[15:11];
                acc_cyc   = c;
                rd_cyc    = err ? -1 : c + 1;
                rd_addr   = grow[10:0];
                resp_cyc  = err ? c + 2 : c + 2 + LAT_A;
                resp_port = e1;
                resp_err  = err;
                resp_data = err ? '0 : pat(grow[10:0]);
                free_at   = resp_cyc + 1;
                ptr_m     = ~e1;
                if (e1) drop1 = 1'b1; else drop0 = 1'b1;
            end
        end
        tick();
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.req0_valid = 1'b0; ifa.req0_row = '0; ifa.req1_valid = 1'b0; ifa.req1_row = '0;
        ifb.req0_valid = 1'b0; ifb.req0_row = '0; ifb.req1_valid = 1'b0; ifb.req1_row = '0;
        test_reset();
        test_single();
        test_out_of_range();
        test_contention();
        test_lat3();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
